// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - 7-segment scan bus receiver: settle, decode, assemble 4-digit frames
module seg_scan_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg_n,
    output logic [13:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {COLLECT, CONV, OUT} state_t;

    logic [10:0]      sync1, sync2, prev;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic [SW-1:0]    settle_cnt;
    logic [IW-1:0]    idle_cnt;
    logic             one_hot, stable, capture, take;
    logic [1:0]       idx, sel;
    logic [3:0]       dec_digit, cap_mask;
    logic             dec_err;
    state_t           state;
    logic [3:0]       have, err;
    logic [3:0][3:0]  dig, snap_d;
    logic             snap_err;
    logic [13:0]      acc, acc_next;
    logic [1:0]       step;

    assign an_s  = sync2[10:7];
    assign seg_s = sync2[6:0];

    // Two-flop synchronizers; prev holds last synced sample for the stability compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {an, seg_n};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Anode position and segment decode of the synced sample
    always_comb begin
        one_hot   = 1'b1;
        idx       = 2'd0;
        dec_digit = 4'd0;
        dec_err   = 1'b0;
        case (an_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
        case (seg_s)
            7'b1000000: dec_digit = 4'd0;
            7'b1111001: dec_digit = 4'd1;
            7'b0100100: dec_digit = 4'd2;
            7'b0110000: dec_digit = 4'd3;
            7'b0011001: dec_digit = 4'd4;
            7'b0010010: dec_digit = 4'd5;
            7'b0000010: dec_digit = 4'd6;
            7'b1111000: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0010000: dec_digit = 4'd9;
            default:    dec_err   = 1'b1;
        endcase
    end

    assign stable   = one_hot && (sync2 == prev);
    assign capture  = stable && (settle_cnt == SETTLE_MAX - SW'(1));
    assign cap_mask = capture ? (4'b0001 << idx) : 4'b0000;
    assign take     = (state == COLLECT) && (have == 4'b1111);
    assign sel      = 2'd3 - step;
    assign acc_next = {acc[10:0], 3'b000} + {acc[12:0], 1'b0} + {10'd0, snap_d[sel]};

    // Settle counter: restarts on any change or non-one-hot anodes, saturates at the threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (!stable) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    // Idle timer: stale once no capture has happened for the timeout period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else if (capture) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else begin
            if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + IW'(1);
            if (idle_cnt >= IDLE_MAX - IW'(1))
                stale <= 1'b1;
        end
    end

    // Digit collection runs in every state; FSM snapshots full frames and converts to binary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= COLLECT;
            have        <= '0;
            err         <= '0;
            dig         <= '0;
            snap_d      <= '0;
            snap_err    <= 1'b0;
            acc         <= '0;
            step        <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            have <= (take ? 4'b0000 : have) | cap_mask;
            err  <= ((take ? 4'b0000 : err) & ~cap_mask) | (dec_err ? cap_mask : 4'b0000);
            if (capture)
                dig[idx] <= dec_digit;
            case (state)
                COLLECT: begin
                    if (take) begin
                        snap_d   <= dig;
                        snap_err <= |err;
                        acc      <= '0;
                        step     <= '0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3)
                        state <= OUT;
                end
                OUT: begin
                    value       <= acc;
                    frame_err   <= snap_err;
                    value_valid <= 1'b1;
                    state       <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed self-checking bench for seg_scan_capture
module tb_seg_scan_capture;

    localparam int TIMEOUT = 300;
    localparam int HOLD    = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an_i = 4'b1111;
    logic [6:0]  seg_i = 7'b1111111;
    logic [13:0] value;
    logic        value_valid, frame_err, stale;

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          pulses_before;
    logic [13:0] last_value = '0;
    logic        last_err = 1'b0;
    logic [6:0]  seg_tab [10];

    seg_scan_capture #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .an(an_i), .seg_n(seg_i),
        .value(value), .value_valid(value_valid), .frame_err(frame_err), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && value_valid) begin
            pulses     = pulses + 1;
            last_value = value;
            last_err   = frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an_i  = a;
        seg_i = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_frame(input int d3, input int d2, input int d1, input int d0);
        show(4'b1110, seg_tab[d0], HOLD);
        show(4'b1101, seg_tab[d1], HOLD);
        show(4'b1011, seg_tab[d2], HOLD);
        show(4'b0111, seg_tab[d3], HOLD);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_value", 32'(value), 32'd0);
        check("reset_valid", 32'(value_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_stale", 32'(stale), 32'd0);

        scan_frame(1, 2, 3, 4);
        check("f1234_pulses", 32'(pulses), 32'd1);
        check("f1234_value", 32'(last_value), 32'd1234);
        check("f1234_ferr", 32'(last_err), 32'd0);
        scan_frame(1, 2, 3, 4);
        check("f1234_repeat_pulses", 32'(pulses), 32'd2);
        check("f1234_repeat_value", 32'(last_value), 32'd1234);
        check("value_hold", 32'(value), 32'd1234);

        scan_frame(9, 9, 9, 9);
        check("f9999_value", 32'(last_value), 32'd9999);
        check("f9999_ferr", 32'(last_err), 32'd0);
        scan_frame(0, 0, 0, 0);
        check("f0000_pulses", 32'(pulses), 32'd4);
        check("f0000_value", 32'(last_value), 32'd0);
        check("f0000_ferr", 32'(last_err), 32'd0);

        show(4'b1110, seg_tab[4], HOLD);
        show(4'b1101, seg_tab[3], HOLD);
        show(4'b1011, seg_tab[2], HOLD);
        show(4'b1101, seg_tab[8], 10);
        check("glitch_no_pulse", 32'(pulses), 32'd4);
        check("glitch_value_kept", 32'(value), 32'd0);
        show(4'b0111, seg_tab[1], HOLD);
        check("glitch_frame_value", 32'(last_value), 32'd1234);

        show(4'b1110, seg_tab[5], HOLD);
        show(4'b1101, seg_tab[6], HOLD);
        show(4'b1011, seg_tab[7], HOLD);
        show(4'b0111, 7'b1111111, HOLD);
        check("bad_digit_value", 32'(last_value), 32'd765);
        check("bad_digit_ferr", 32'(last_err), 32'd1);

        pulses_before = pulses;
        show(4'b1110, seg_tab[1], HOLD);
        show(4'b1101, seg_tab[2], HOLD);
        show(4'b1011, seg_tab[3], HOLD);
        show(4'b0111, seg_tab[4], 21);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_conv_no_pulse", 32'(pulses), 32'(pulses_before));
        check("reset_conv_value", 32'(value), 32'd0);
        check("reset_conv_ferr", 32'(frame_err), 32'd0);
        check("reset_conv_stale", 32'(stale), 32'd0);
        scan_frame(4, 3, 2, 1);
        check("after_reset_value", 32'(last_value), 32'd4321);
        check("after_reset_ferr", 32'(last_err), 32'd0);
        check("after_reset_pulses", 32'(pulses), 32'(pulses_before + 1));

        show(4'b1111, 7'b1111111, 100);
        check("stale_early", 32'(stale), 32'd0);
        show(4'b1111, 7'b1111111, TIMEOUT);
        check("stale_set", 32'(stale), 32'd1);
        show(4'b1110, seg_tab[7], HOLD);
        check("stale_cleared", 32'(stale), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
